// File: rtl/fwrisc_alu_pkg.sv
// ============================================================================
// Module   : fwrisc_alu_pkg
// Brief    : Shared op codes, FSM states and helpers for the multi-cycle ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fwrisc_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift(alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwrisc_shift_step.sv
// ============================================================================
// Module   : fwrisc_shift_step
// Brief    : Combinational shift of one iteration, 0..SHIFT_STEP bit positions.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fwrisc_shift_step
  import fwrisc_alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic [WIDTH-1:0]             data,
  input  logic [$clog2(SHIFT_STEP):0]  amount,
  input  logic [3:0]                   kind,
  output logic [WIDTH-1:0]             result
);

  always_comb begin
    result = data;
    case (alu_op_t'(kind))
      ALU_SLL: result = data << amount;
      ALU_SRL: result = data >> amount;
      ALU_SRA: result = $unsigned($signed(data) >>> amount);
      default: result = data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fwrisc_alu_mc.sv
// ============================================================================
// Module   : fwrisc_alu_mc
// Brief    : Multi-cycle ALU with iterative shifts, compares and valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fwrisc_alu_mc
  import fwrisc_alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             eqz,
  output logic             lt,
  output logic             ltu
);

  localparam int c_cnt_w  = $clog2(WIDTH);
  localparam int c_step_w = $clog2(SHIFT_STEP) + 1;

  alu_state_t           r_state;
  alu_state_t           w_state_nxt;
  alu_op_t              r_op;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_out;
  logic                 r_eqz;
  logic                 r_lt;
  logic                 r_ltu;

  alu_op_t              w_op;
  logic [c_cnt_w-1:0]   w_shamt;
  logic                 w_accept;
  logic                 w_shift_start;
  logic                 w_last;
  logic [c_step_w-1:0]  w_step;
  logic [WIDTH-1:0]     w_result;
  logic [WIDTH-1:0]     w_shifted;
  logic                 w_eqz;
  logic                 w_lt;
  logic                 w_ltu;

  assign w_op          = alu_op_t'(op);
  assign w_shamt       = op_b[c_cnt_w-1:0];
  assign w_accept      = in_valid && in_ready;
  assign w_shift_start = is_shift(w_op) && (w_shamt != '0);

  // Final iteration when what remains fits in one step; the step is then the remainder.
  assign w_last = (32'(r_cnt) <= 32'(SHIFT_STEP));
  assign w_step = w_last ? c_step_w'(r_cnt) : c_step_w'(SHIFT_STEP);

  assign w_eqz = (op_a == op_b);
  assign w_lt  = ($signed(op_a) < $signed(op_b));
  assign w_ltu = (op_a < op_b);

  always_comb begin
    w_result = op_a | op_b;
    case (w_op)
      ALU_ADD:  w_result = op_a + op_b;
      ALU_SUB:  w_result = op_a - op_b;
      ALU_AND:  w_result = op_a & op_b;
      ALU_XOR:  w_result = op_a ^ op_b;
      ALU_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_lt};
      ALU_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_ltu};
      ALU_SLL, ALU_SRL, ALU_SRA: w_result = op_a;
      default:  w_result = op_a | op_b;
    endcase
  end

  fwrisc_shift_step #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift_step (
    .data   (r_out),
    .amount (w_step),
    .kind   (r_op),
    .result (w_shifted)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // DONE with out_ready behaves exactly like IDLE so back-to-back ops issue every cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_shift_start ? ST_SHIFT : ST_DONE;
        end else if (r_state == ST_DONE && out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op  <= ALU_ADD;
      r_cnt <= '0;
      r_out <= '0;
      r_eqz <= 1'b0;
      r_lt  <= 1'b0;
      r_ltu <= 1'b0;
    end else if (w_accept) begin
      r_op  <= w_op;
      r_cnt <= w_shamt;
      r_out <= w_result;
      r_eqz <= w_eqz;
      r_lt  <= w_lt;
      r_ltu <= w_ltu;
    end else if (r_state == ST_SHIFT) begin
      r_out <= w_shifted;
      r_cnt <= r_cnt - c_cnt_w'(w_step);
    end
  end

  assign out = r_out;
  assign eqz = r_eqz;
  assign lt  = r_lt;
  assign ltu = r_ltu;

endmodule

`default_nettype wire

// File: tb/tb_fwrisc_alu_mc.sv
// ============================================================================
// Module   : tb_fwrisc_alu_mc
// Brief    : Scoreboard bench for fwrisc_alu_mc with WIDTH=32, SHIFT_STEP=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fwrisc_alu_mc;
  import fwrisc_alu_pkg::*;

  localparam int WIDTH      = 32;
  localparam int SHIFT_STEP = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out;
  logic              eqz;
  logic              lt;
  logic              ltu;

  typedef struct {
    logic [31:0] out;
    logic [2:0]  flags;   // {eqz, lt, ltu}
    int          start;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic seen     = 1'b0;
  int   start_cyc = 0;

  fwrisc_alu_mc #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .eqz       (eqz),
    .lt        (lt),
    .ltu       (ltu)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: records the first cycle a result is presented, compares on handshake.
  always @(negedge clock) begin
    exp_t e;
    if (!out_valid) begin
      seen = 1'b0;
    end else begin
      if (!seen) begin
        seen = 1'b1;
        start_cyc = cyc;
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%08h, expected no result", out);
        end else begin
          e = sb.pop_front();
          check($sformatf("op%0d_out", e.id), out, e.out);
          check($sformatf("op%0d_flags", e.id), {29'd0, eqz, lt, ltu}, {29'd0, e.flags});
          check($sformatf("op%0d_valid_cycle", e.id), start_cyc, e.start);
        end
        seen = 1'b0;
      end
    end
  end

  // Present an op (in_valid stays high afterwards) and push its expected response.
  task automatic issue(input int id, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eout,
                       input logic [2:0] eflags, input int lat, output int t_acc);
    int   k;
    exp_t e;
    op       = o;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    t_acc    = -1;
    for (k = 0; k < 50; k++) begin
      @(negedge clock);
      if (in_ready) break;
    end
    if (k == 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL op%0d_accept_timeout: in_ready low for 50 cycles, expected acceptance", id);
      in_valid = 1'b0;
      return;
    end
    t_acc   = cyc;
    e.out   = eout;
    e.flags = eflags;
    e.start = cyc + lat;
    e.id    = id;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int   t;
    int   t_first;
    int   c_raise;
    int   k;
    exp_t dummy;

    in_valid  = 1'b0;
    op        = 4'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    out_ready = 1'b1;

    // Reset values while held in reset.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_flags", {29'd0, eqz, lt, ltu}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    wait_cycles(1);

    issue(1, ALU_SUB,  32'd5,          32'd7,  32'hFFFF_FFFE, 3'b011, 1, t);
    issue(2, ALU_SLTU, 32'hFFFF_FFFF,  32'd1,  32'h0000_0000, 3'b010, 1, t);
    issue(3, ALU_SRA,  32'h8000_0000,  32'd31, 32'hFFFF_FFFF, 3'b010, 9, t);
    in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      check($sformatf("sra_in_ready_T+%0d", i), {31'd0, in_ready}, 32'd0);
    end
    issue(4, ALU_SLL,  32'd1,          32'd0,  32'h0000_0001, 3'b000, 1, t);
    issue(5, ALU_SRL,  32'hF000_0000,  32'd6,  32'h03C0_0000, 3'b010, 3, t);
    issue(6, ALU_SLL,  32'd3,          32'd5,  32'h0000_0060, 3'b011, 3, t);
    issue(7, ALU_SRL,  32'h8000_0000,  32'h24, 32'h0800_0000, 3'b010, 2, t);

    // Back-to-back non-shift ops: one accepted every cycle.
    issue(8,  ALU_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 3'b010, 1, t_first);
    issue(9,  ALU_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 3'b000, 1, t);
    issue(10, ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 3'b011, 1, t);
    issue(11, ALU_SLT,  32'hFFFF_FFFE, 32'd3,         32'h0000_0001, 3'b010, 1, t);
    issue(12, ALU_ADD,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 3'b010, 1, t);
    issue(13, ALU_SUB,  32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 3'b100, 1, t);
    issue(14, 4'hF,     32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 3'b000, 1, t);
    in_valid = 1'b0;
    check("b2b_accept_span", t - t_first, 32'd6);
    wait_cycles(2);

    // Backpressure: result and flags held, no acceptance.
    out_ready = 1'b0;
    issue(15, ALU_XOR, 32'h0F0F_0F0F, 32'h0000_00FF, 32'h0F0F_0FF0, 3'b000, 1, t);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("hold%0d_out", i), out, 32'h0F0F_0FF0);
      check($sformatf("hold%0d_flags", i), {29'd0, eqz, lt, ltu}, 32'd0);
      check($sformatf("hold%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      check($sformatf("hold%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    c_raise   = cyc;
    issue(16, ALU_ADD, 32'd2, 32'd3, 32'd5, 3'b011, 1, t);
    in_valid = 1'b0;
    check("release_accept_cycle", t, c_raise);
    wait_cycles(2);

    // Reset during a shift drops the op.
    issue(17, ALU_SLL, 32'd1, 32'd31, 32'h8000_0000, 3'b011, 9, t);
    in_valid = 1'b0;
    wait_cycles(3);
    reset = 1'b0;
    #1;
    if (sb.size() > 0) dummy = sb.pop_back();
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out", out, 32'd0);
    check("midrst_flags", {29'd0, eqz, lt, ltu}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    issue(18, ALU_ADD, 32'h10, 32'h20, 32'h30, 3'b011, 1, t);
    in_valid = 1'b0;

    for (k = 0; k < 50 && sb.size() != 0; k++) @(posedge clock);
    @(negedge clock);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
